// File: rtl/seq_subtractor.sv
// Digit-serial subtractor: Y = A - B, DIGIT bits per cycle, LSB digit first.
// Define SEQ_SUBTRACTOR_OVF_EN to add the signed-overflow output OVF.
module seq_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             READY,
  output logic             VALID,
  input  logic             ACK,
  output logic [WIDTH-1:0] Y,
`ifdef SEQ_SUBTRACTOR_OVF_EN
  output logic             OVF,
`endif
  output logic             BO
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(NDIG + 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("seq_subtractor: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               borrow_q, borrow_d;
  logic               bo_q, bo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT:0]     digit_diff;
  logic [WIDTH+DIGIT-1:0] res_shift;
  logic               last_digit;
`ifdef SEQ_SUBTRACTOR_OVF_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               ovf_q, ovf_d;
`endif

  // Bit DIGIT of the extended difference is the borrow out of this digit.
  assign digit_diff = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
                      - {{DIGIT{1'b0}}, borrow_q};
  assign res_shift  = {digit_diff[DIGIT-1:0], res_q};
  assign last_digit = (cnt_q == CNT_W'(NDIG - 1));

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      y_q      <= '0;
      borrow_q <= 1'b0;
      bo_q     <= 1'b0;
      cnt_q    <= '0;
`ifdef SEQ_SUBTRACTOR_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      y_q      <= y_d;
      borrow_q <= borrow_d;
      bo_q     <= bo_d;
      cnt_q    <= cnt_d;
`ifdef SEQ_SUBTRACTOR_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START)      state_d = RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    if (ACK)        state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    y_d      = y_q;
    borrow_d = borrow_q;
    bo_d     = bo_q;
    cnt_d    = cnt_q;
`ifdef SEQ_SUBTRACTOR_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (START) begin
          a_d      = A;
          b_d      = B;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
`ifdef SEQ_SUBTRACTOR_OVF_EN
          // Operands are shifted away during RUN, so keep their signs.
          a_msb_d  = A[WIDTH-1];
          b_msb_d  = B[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        res_d    = res_shift[WIDTH+DIGIT-1:DIGIT];
        borrow_d = digit_diff[DIGIT];
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_digit) begin
          y_d  = res_shift[WIDTH+DIGIT-1:DIGIT];
          bo_d = digit_diff[DIGIT];
`ifdef SEQ_SUBTRACTOR_OVF_EN
          ovf_d = (a_msb_q != b_msb_q) && (digit_diff[DIGIT-1] != a_msb_q);
`endif
        end
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    READY = (state_q == IDLE);
    VALID = (state_q == DONE);
  end

  assign Y  = y_q;
  assign BO = bo_q;
`ifdef SEQ_SUBTRACTOR_OVF_EN
  assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// Directed self-checking bench for seq_subtractor (defaults WIDTH=32, DIGIT=4).
// Build with SEQ_SUBTRACTOR_OVF_EN defined to also check OVF.
module tb_seq_subtractor;

  localparam int W   = 32;
  localparam int LAT = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         READY;
  logic         VALID;
  logic         ACK;
  logic [W-1:0] Y;
  logic         BO;
`ifdef SEQ_SUBTRACTOR_OVF_EN
  logic         OVF;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_subtractor #(.WIDTH(W), .DIGIT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .START (START),
    .A     (A),
    .B     (B),
    .READY (READY),
    .VALID (VALID),
    .ACK   (ACK),
    .Y     (Y),
`ifdef SEQ_SUBTRACTOR_OVF_EN
    .OVF   (OVF),
`endif
    .BO    (BO)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         bo;
    logic         ovf;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_result(input string name, input logic [W-1:0] ey, input logic ebo,
                              input logic eovf);
    check({name, " Y"}, Y, ey);
    check({name, " BO"}, {31'd0, BO}, {31'd0, ebo});
`ifdef SEQ_SUBTRACTOR_OVF_EN
    check({name, " OVF"}, {31'd0, OVF}, {31'd0, eovf});
`else
    if (eovf === 1'bx) $display("unexpected x in expected OVF for %s", name);
`endif
  endtask

  // Accept START at the next edge; return at the negedge where VALID was first seen.
  // If disturb is set, START is toggled and A/B scrambled throughout RUN.
  task automatic start_and_wait(input string name, input logic [W-1:0] a,
                                input logic [W-1:0] b, input bit disturb);
    int lat;
    START = 1'b1;
    A = a;
    B = b;
    @(negedge clk);
    START = 1'b0;
    check({name, " READY after accept"}, {31'd0, READY}, 32'd0);
    lat = 0;
    while (!VALID && lat < 3 * LAT) begin
      if (disturb) begin
        START = ~START;
        A = $urandom;
        B = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    START = 1'b0;
    check({name, " latency"}, lat, LAT);
  endtask

  task automatic do_ack();
    ACK = 1'b1;
    @(negedge clk);
    ACK = 1'b0;
  endtask

  vec_t vecs[8];
  logic [W-1:0] y_hold;

  initial begin
    vecs[0] = '{32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 1'b0};
    vecs[1] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[3] = '{32'h00000010, 32'h00000001, 32'h0000000F, 1'b0, 1'b0};
    vecs[4] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0};
    vecs[6] = '{32'h00000001, 32'h80000000, 32'h80000001, 1'b1, 1'b1};
    vecs[7] = '{32'hDEADBEEF, 32'h01234567, 32'hDD8A7988, 1'b0, 1'b0};

    rst = 1'b1; START = 1'b0; ACK = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("reset READY", {31'd0, READY}, 32'd1);
    check("reset VALID", {31'd0, VALID}, 32'd0);
    check_result("reset", 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // ACK in IDLE must do nothing
    ACK = 1'b1;
    @(negedge clk);
    ACK = 1'b0;
    check("ack in idle READY", {31'd0, READY}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      start_and_wait($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1'b0);
      check_result($sformatf("vec%0d", i), vecs[i].y, vecs[i].bo, vecs[i].ovf);
      $display("vec%0d: A=0x%08h B=0x%08h -> Y=0x%08h BO=%0b", i, vecs[i].a, vecs[i].b, Y, BO);
      do_ack();
      check($sformatf("vec%0d READY after ack", i), {31'd0, READY}, 32'd1);
    end

    // Equal operands with START toggling and A/B changing during RUN
    start_and_wait("equal+disturb", 32'h12345678, 32'h12345678, 1'b1);
    check_result("equal+disturb", 32'd0, 1'b0, 1'b0);
    $display("equal+disturb: Y=0x%08h BO=%0b", Y, BO);

    // Hold in DONE without ACK: VALID and Y stable
    y_hold = Y;
    for (int i = 0; i < 20; i++) begin
      START = i[0];
      @(negedge clk);
      check("done hold VALID", {31'd0, VALID}, 32'd1);
      check("done hold Y", Y, 32'd0);
    end
    A = 32'h00000009;
    B = 32'h00000001;
    START = 1'b1;
    ACK = 1'b1;
    @(negedge clk);
    START = 1'b0;
    ACK = 1'b0;
    check("ack+start READY", {31'd0, READY}, 32'd1);
    check("ack+start VALID", {31'd0, VALID}, 32'd0);
    repeat (LAT + 2) @(negedge clk);
    check("no second op READY", {31'd0, READY}, 32'd1);
    check("no second op VALID", {31'd0, VALID}, 32'd0);
    check("result held in IDLE", Y, y_hold);
    $display("ack+start: READY=%0b VALID=%0b Y=0x%08h", READY, VALID, Y);

    // Give Y a nonzero value, then reset at RUN cycle 4
    start_and_wait("pre-reset", 32'h00000005, 32'h00000003, 1'b0);
    check_result("pre-reset", 32'h00000002, 1'b0, 1'b0);
    do_ack();
    START = 1'b1;
    A = 32'hFFFF0000;
    B = 32'h0000FFFF;
    @(negedge clk);
    START = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    START = 1'b1;
    ACK = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    START = 1'b0;
    ACK = 1'b0;
    check("mid-run reset READY", {31'd0, READY}, 32'd1);
    check("mid-run reset VALID", {31'd0, VALID}, 32'd0);
    check_result("mid-run reset", 32'd0, 1'b0, 1'b0);
    $display("mid-run reset: READY=%0b VALID=%0b Y=0x%08h BO=%0b", READY, VALID, Y, BO);

    start_and_wait("after reset", 32'h00000100, 32'h00000101, 1'b0);
    check_result("after reset", 32'hFFFFFFFF, 1'b1, 1'b0);
    $display("after reset: Y=0x%08h BO=%0b", Y, BO);
    do_ack();

    // Reset while in DONE
    start_and_wait("done reset", 32'h00000003, 32'h00000007, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("done reset VALID", {31'd0, VALID}, 32'd0);
    check_result("done reset", 32'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_subtractor.md
SEQ_SUBTRACTOR -- requirements
Module: seq_subtractor

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 The block SHALL take parameter DIGIT, default 4, the bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port START, input, 1 bit: request a subtraction of A and B.
REQ-006 The block SHALL have port A, input, WIDTH bits: minuend, sampled only when START is accepted.
REQ-007 The block SHALL have port B, input, WIDTH bits: subtrahend, sampled only when START is accepted.
REQ-008 The block SHALL have port READY, output, 1 bit: the block is idle and accepts START.
REQ-009 The block SHALL have port VALID, output, 1 bit: Y and BO hold a completed result.
REQ-010 The block SHALL have port ACK, input, 1 bit: the consumer has taken the result.
REQ-011 The block SHALL have port Y, output, WIDTH bits: A minus B, modulo 2^WIDTH.
REQ-012 The block SHALL have port BO, output, 1 bit: borrow out, 1 iff A < B unsigned.

Function
REQ-013 The block SHALL implement three states, IDLE, RUN and DONE; READY SHALL be 1 only in IDLE and VALID SHALL be 1 only in DONE.
REQ-014 In IDLE, START=1 SHALL capture A and B, clear the internal borrow to 0, clear the digit counter to 0 and move the block to RUN on that edge.
REQ-015 In RUN, each cycle SHALL subtract the lowest DIGIT bits of the operand registers with the running borrow, shift the difference digit into the result shift register from the MSB side, shift both operand registers right by DIGIT, and update the borrow.
REQ-016 After WIDTH/DIGIT RUN cycles, the block SHALL load Y from the result shift register and BO from the final borrow, and enter DONE on that same edge.
REQ-017 Latency SHALL be fixed: VALID rises exactly WIDTH/DIGIT rising edges after the edge that accepted START (8 edges at the defaults), independent of the data.
REQ-018 In DONE, VALID SHALL remain 1 with Y and BO stable until ACK=1 is sampled; the block SHALL then return to IDLE on that edge.
REQ-019 START SHALL be ignored in RUN and DONE; START and ACK sampled on the same edge in DONE SHALL only complete the ACK, and no new operation SHALL begin.
REQ-020 ACK SHALL be ignored outside DONE.
REQ-021 Y and BO SHALL hold the last completed result until the next completion; input changes on A and B after acceptance SHALL NOT affect the result.

Reset
REQ-022 With rst=1 sampled, the block SHALL enter IDLE and set READY=1, VALID=0, Y=0, BO=0, clear all internal registers, and clear OVF (when present).
REQ-023 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result delivered; rst SHALL take priority over START and ACK.

Configuration
REQ-024 With macro SEQ_SUBTRACTOR_OVF_EN defined, the block SHALL add port OVF, output, 1 bit, loaded at completion with the signed overflow: (A[MSB] != B[MSB]) and (Y[MSB] != A[MSB]). It SHALL hold OVF with Y and reset it to 0.
REQ-025 Without SEQ_SUBTRACTOR_OVF_EN, the OVF port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 The bench SHALL apply A=5, B=3 with START in IDLE -> VALID after 8 edges, Y=0x00000002, BO=0.
REQ-027 The bench SHALL apply A=0x00000000, B=0x00000001 -> Y=0xFFFFFFFF, BO=1; with the macro, OVF=0.
REQ-028 With the macro, the bench SHALL apply A=0x80000000, B=0x00000001 -> Y=0x7FFFFFFF, BO=0, OVF=1.
REQ-029 The bench SHALL apply A=0x12345678, B=0x12345678, then toggle START and change A and B during RUN -> Y=0, BO=0 with latency unchanged and no second operation started.
REQ-030 The bench SHALL hold ACK=0 for 20 cycles in DONE -> VALID=1 and Y stable throughout; it SHALL then pulse ACK together with START -> IDLE next edge with READY=1 and no new operation started.
REQ-031 The bench SHALL assert rst at RUN cycle 4 -> next edge READY=1, VALID=0, Y=0, BO=0; a new START SHALL then complete correctly in 8 edges.
